// File: rtl/subtrator_serial.sv
// subtrator_serial: word-serial A - B - Bin over WORDS x WIDTH-bit operands,
// least-significant word first, with the borrow carried in a register.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   in_valid/in_ready  input handshake for one A/B word (Bin used on word 0)
//   A, B, Bin          minuend word, subtrahend word, initial borrow
//   out_valid/out_ready output handshake for one result word
//   S, Bout            difference word and its borrow out
//   out_last           result word is the last word of the operation
//   zero               whole-operation result is zero (valid with out_last)
//   ovf                signed overflow on the last word; present only when
//                      SUBTRATOR_OVF_EN is defined
module subtrator_serial #(
    parameter int WIDTH = 8,
    parameter int WORDS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Bout,
    output logic             out_last,
    output logic             zero
`ifdef SUBTRATOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    logic [IW-1:0]    idx;
    logic             brw;
    logic             zacc;
    logic             acc;
    logic             is_last;
    logic             cin;
    logic             bw;
    logic             bo;
    logic [WIDTH-1:0] s_nxt;

    // Single output register: a new word may enter only if the slot is
    // empty or being emptied this cycle.
    assign in_ready = !out_valid || out_ready;
    assign acc      = in_valid && in_ready;
    assign is_last  = (idx == LAST);
    assign cin      = (idx == '0) ? Bin : brw;

    // Ripple borrow chain, LSB to MSB.
    always_comb begin
        bw    = cin;
        s_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s_nxt[i] = A[i] ^ B[i] ^ bw;
            bw       = (~A[i] & (B[i] | bw)) | (B[i] & bw);
        end
        bo = bw;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            brw       <= 1'b0;
            zacc      <= 1'b0;
            out_valid <= 1'b0;
            S         <= '0;
            Bout      <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (acc) begin
                S         <= s_nxt;
                Bout      <= bo;
                out_last  <= is_last;
                out_valid <= 1'b1;
                // The borrow never leaks into the next operation.
                brw       <= is_last ? 1'b0 : bo;
                idx       <= is_last ? '0 : idx + 1'b1;
                zacc      <= (idx == '0) ? (s_nxt == '0)
                                         : (zacc && (s_nxt == '0));
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign zero = zacc && out_last;

`ifdef SUBTRATOR_OVF_EN
    // Sign bits of the top word decide two's-complement overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (acc) begin
            ovf <= is_last
                && (A[WIDTH-1] != B[WIDTH-1])
                && (s_nxt[WIDTH-1] != A[WIDTH-1]);
        end
    end
`endif

endmodule

// File: doc/subtrator_serial.md
# subtrator_serial

Parametrised multi-word subtractor: computes A − B − Bin on operands of WORDS × WIDTH bits, one WIDTH-bit word per accepted beat, least-significant word first. The borrow is held in a register between words, so arbitrarily wide subtractions run on a narrow datapath. It is the sequential successor of the 8-bit ripple subtractor in the arithmetic library. Valid/ready handshakes are on both sides, with one registered output stage.

## Interface
- WIDTH, 8: bits per word (≥ 1).
- WORDS, 4: words per operation (≥ 1); operation width = WORDS × WIDTH.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  A/B/Bin word present.
- in_ready  output  1  block accepts a word this cycle.
- A  input  WIDTH  minuend word.
- B  input  WIDTH  subtrahend word.
- Bin  input  1  initial borrow; sampled only on word 0 of an operation.
- out_valid  output  1  result word held in output register.
- out_ready  input  1  downstream accepts the result word.
- S  output  WIDTH  difference word.
- Bout  output  1  borrow out of this word.
- out_last  output  1  result word is word WORDS−1 of the operation.
- zero  output  1  whole operation result is zero; meaningful only when out_last=1, otherwise 0.

## Operation
- Accept: in_valid && in_ready. Out-take: out_valid && out_ready.
- in_ready = !out_valid || out_ready (single output register, no skid buffer).
- Word index counter idx, width clog2(WORDS) (minimum 1 bit), reset value 0.
  - Increments on each accept.
  - Wraps WORDS−1 → 0.
- Borrow into the current word:
  - idx == 0: Bin.
  - otherwise: borrow register brw.
- Word arithmetic:
  - {Bo, S_next} = A − B − borrow_in, computed as a WIDTH-bit ripple borrow chain.
  - Bo = 1 when A < B + borrow_in, unsigned.
- On accept:
  - Register S ← S_next, Bout ← Bo, out_last ← (idx == WORDS−1).
  - brw ← Bo; cleared to 0 when idx == WORDS−1.
  - out_valid ← 1.
- On out-take without a same-cycle accept: out_valid ← 0.
- Simultaneous out-take and accept: the output register reloads and out_valid stays 1.
- Zero accumulator zacc:
  - On accept with idx == 0: zacc ← (S_next == 0).
  - On other accepts: zacc ← zacc && (S_next == 0).
  - zero output = zacc && out_last.
- WORDS = 1: every word is word 0 and last; the block behaves as a registered single-word subtractor.
- Reset, including mid-operation: idx = 0, brw = 0, zacc = 0, out_valid = 0, S = 0, Bout = 0, out_last = 0, zero = 0, ovf = 0. A partially processed operation is discarded and the next accepted word is word 0.
- Output fields do not change while out_valid && !out_ready.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 word per cycle while out_ready = 1.
- A full operation completes WORDS cycles after its first accept.
- Critical path: A/B → WIDTH-bit borrow chain → S/Bout registers.
- in_ready is combinational from out_valid and out_ready only; there is no path from in_valid to in_ready.
- Output register fields (S, Bout, out_last, zacc, ovf) update only on accept. out_valid additionally clears on out-take without a same-cycle accept.

## Configuration
- SUBTRATOR_OVF_EN defined:
  - Adds output port ovf (1 bit, registered, reset value 0).
  - On the last word, ovf = two's-complement signed overflow of the full operation: A[msb] ≠ B[msb] && S_next[msb] ≠ A[msb].
  - ovf is 0 on all non-last words.
- SUBTRATOR_OVF_EN undefined:
  - Port ovf does not exist.
  - No overflow logic is synthesised.
  - All other behaviour is identical.

## Test plan
- WIDTH=8, WORDS=2, out_ready=1, A=0x1234, B=0x0235, Bin=0 → words S=0xFF/Bout=1, then S=0x0F/Bout=0/out_last=1; result 0x0FFF, zero=0.
- WIDTH=8, WORDS=2, A=0x0000, B=0x0001, Bin=0 → S=0xFF, 0xFF; final Bout=1. Then a back-to-back operation 0x0005−0x0003 → 0x0002 with word-0 borrow-in equal to Bin (not the stale 1).
- WIDTH=8, WORDS=2, A=0x5A5A, B=0x5A5A, Bin=0 → S=0x00, 0x00; zero=1 on the last word only.
- Backpressure: hold out_ready=0 for 3 cycles after the first accept → in_ready=0 and S/Bout/out_last stable for those 3 cycles; words then complete in order with no loss or duplication.
- Reset mid-operation: accept word 0 of 0x0100−0x0001 (word 0 produces Bout=1), assert rst for 1 cycle → all outputs 0; then 0x0003−0x0001 → 0x0002 with no stale borrow.
- With SUBTRATOR_OVF_EN, WORDS=2: 0x8000−0x0001 → 0x7FFF with ovf=1; 0x0001−0x0002 → 0xFFFF with ovf=0 and final Bout=1.
